// File: rtl/spi_adc_slave.sv
// -----------------------------------------------------------------------------
// spi_adc_slave
//
// SPI responder that stands in for a 12-bit ADC at the far end of the spi_wr
// link. It receives an 8-bit command MSB-first on mosi_i and returns a DW-bit
// sample MSB-first on miso_o. All logic runs in the clk_i domain. The SPI
// inputs are oversampled through SYNC_STAGES flops, and the dclk edges are
// detected on the synchronized copy.
//
// Frame layout (dclk rising edges, cs low throughout):
//   1..8    command bits. Bit 7 is the start bit and bits 6:4 are the channel.
//   9       busy bit, miso low.
//   10..21  sample bits 11..0. Each bit is driven on the falling edge after
//           the previous rising edge.
//   22..24  tail, miso low. A done strobe follows edge 24.
//
// Ports
//   clk_i      system clock
//   rst_i      asynchronous reset, active low
//   dclk_i     SPI clock from the master, idle low
//   cs_i       chip select from the master, active low
//   mosi_i     command data from the master
//   sample_i   value returned in this frame, captured once the command
//              has been decoded
//   miso_o     serial data to the master. Held low whenever cs is high.
//   cmd_o      last command byte that carried a start bit
//   chan_o     channel field of cmd_o (bits 6:4)
//   cmd_vld_o  one-cycle strobe when a command with a start bit is decoded
//   busy_o     high while a frame is in progress
//   done_o     one-cycle strobe when a frame completes its 24th edge
//
// Build option
//   ADC_EMU_RAMP_EN  When defined, sample_i is ignored. The returned value is
//                    an internal ramp that starts at 0 and advances by
//                    chan_o+1 after every done_o, wrapping modulo 2**DW.
// -----------------------------------------------------------------------------
module spi_adc_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int DW          = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          dclk_i,
    input  logic          cs_i,
    input  logic          mosi_i,
    input  logic [DW-1:0] sample_i,
    output logic          miso_o,
    output logic [7:0]    cmd_o,
    output logic [2:0]    chan_o,
    output logic          cmd_vld_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int IW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_CONV   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_TAIL   = 3'd4;
    localparam logic [2:0] ST_WAITCS = 3'd5;
    localparam logic [2:0] ST_SKIP   = 3'd6;

    localparam logic [4:0] CNT_CMD_LAST   = 5'd8;
    localparam logic [4:0] CNT_DATA_LAST  = 5'(8 + DW);
    localparam logic [4:0] CNT_TAIL_FIRST = 5'(9 + DW);
    localparam logic [4:0] CNT_FRAME_LAST = 5'd24;

    logic [SYNC_STAGES-1:0] dclk_sync_q, dclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   dclk_prev_q, dclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;

    logic [2:0]    state_q,   state_d;
    logic [4:0]    cnt_q,     cnt_d;
    logic [7:0]    cmd_sh_q,  cmd_sh_d;
    logic [7:0]    cmd_q,     cmd_d;
    logic [2:0]    chan_q,    chan_d;
    logic          cmd_vld_q, cmd_vld_d;
    logic [DW-1:0] sample_q,  sample_d;
    logic          miso_q,    miso_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;

    logic          dclk_s, cs_s, mosi_s;
    logic          rise_s, fall_s, cs_fall_s;
    logic [4:0]    cnt_inc_s;
    logic [7:0]    cmd_next_s;
    logic [IW-1:0] bit_idx_s;
    logic [DW-1:0] ret_val_s;

`ifdef ADC_EMU_RAMP_EN
    logic [DW-1:0] ramp_q, ramp_d;
    logic          unused_sample_s;

    assign unused_sample_s = ^sample_i;
    assign ret_val_s       = ramp_q;

    // Ramp source: advance by channel+1 once per completed frame.
    always_comb begin
        ramp_d = ramp_q;
        if (done_d) begin
            ramp_d = ramp_q + DW'(chan_q) + DW'(1'b1);
        end else begin
            ramp_d = ramp_q;
        end
    end

    // Ramp register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ramp_q <= {DW{1'b0}};
        end else begin
            ramp_q <= ramp_d;
        end
    end
`else
    assign ret_val_s = sample_i;
`endif

    // Input synchronizers and edge-detect history.
    always_comb begin
        dclk_sync_d = {dclk_sync_q[SYNC_STAGES-2:0], dclk_i};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   cs_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        dclk_prev_d = dclk_s;
        cs_prev_d   = cs_s;
    end

    assign dclk_s    = dclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign rise_s    = dclk_s & ~dclk_prev_q;
    assign fall_s    = ~dclk_s & dclk_prev_q;
    assign cs_fall_s = ~cs_s & cs_prev_q;

    // The edge counter stops at 24, so extra edges cannot wrap it back into the data window.
    assign cnt_inc_s  = (cnt_q >= CNT_FRAME_LAST) ? cnt_q : (cnt_q + 5'd1);
    assign cmd_next_s = {cmd_sh_q[6:0], mosi_s};
    // After edge n (9..8+DW) the falling edge presents sample bit (8+DW)-n.
    assign bit_idx_s  = IW'(CNT_DATA_LAST - cnt_q);

    // Frame sequencer: command capture, sample latch and serial output.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_sh_d  = cmd_sh_q;
        cmd_d     = cmd_q;
        chan_d    = chan_q;
        sample_d  = sample_q;
        miso_d    = miso_q;
        cmd_vld_d = 1'b0;
        done_d    = 1'b0;

        // cs going high ends the frame in any state. It also forces miso low.
        if ((state_q != ST_IDLE) && cs_s) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    // A dclk rise coincident with cs falling is deliberately dropped.
                    if (cs_fall_s) begin
                        state_d  = ST_CMD;
                        cnt_d    = 5'd0;
                        cmd_sh_d = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    miso_d = 1'b0;
                    if (rise_s) begin
                        cnt_d    = cnt_inc_s;
                        cmd_sh_d = cmd_next_s;
                        if (cnt_inc_s == CNT_CMD_LAST) begin
                            if (cmd_next_s[7]) begin
                                state_d   = ST_CONV;
                                cmd_d     = cmd_next_s;
                                chan_d    = cmd_next_s[6:4];
                                cmd_vld_d = 1'b1;
                                sample_d  = ret_val_s;
                            end else begin
                                state_d = ST_SKIP;
                            end
                        end else begin
                            state_d = ST_CMD;
                        end
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_CONV: begin
                    miso_d = 1'b0;
                    if (rise_s) begin
                        cnt_d   = cnt_inc_s;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_CONV;
                    end
                end
                ST_DATA: begin
                    if (rise_s) begin
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s == CNT_TAIL_FIRST) begin
                            state_d = ST_TAIL;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else if (fall_s) begin
                        miso_d = sample_q[bit_idx_s];
                    end else begin
                        miso_d = miso_q;
                    end
                end
                ST_TAIL: begin
                    // The last data bit stays on the line until the falling edge after its capture.
                    if (rise_s) begin
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s == CNT_FRAME_LAST) begin
                            state_d = ST_WAITCS;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_TAIL;
                        end
                    end else if (fall_s) begin
                        miso_d = 1'b0;
                    end else begin
                        miso_d = miso_q;
                    end
                end
                ST_WAITCS, ST_SKIP: begin
                    miso_d = 1'b0;
                    if (rise_s) begin
                        cnt_d = cnt_inc_s;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dclk_sync_q <= {SYNC_STAGES{1'b0}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            dclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            cmd_sh_q    <= 8'd0;
            cmd_q       <= 8'd0;
            chan_q      <= 3'd0;
            cmd_vld_q   <= 1'b0;
            sample_q    <= {DW{1'b0}};
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            dclk_sync_q <= dclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            dclk_prev_q <= dclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_sh_q    <= cmd_sh_d;
            cmd_q       <= cmd_d;
            chan_q      <= chan_d;
            cmd_vld_q   <= cmd_vld_d;
            sample_q    <= sample_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign miso_o    = miso_q;
    assign cmd_o     = cmd_q;
    assign chan_o    = chan_q;
    assign cmd_vld_o = cmd_vld_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_spi_adc_slave.sv
// Self-checking bench for spi_adc_slave. The bench acts as an SPI master and
// keeps a frame-level model of what the responder must present.
module tb_spi_adc_slave;
    localparam int DW = 12;
    localparam int SS = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          dclk_i;
    logic          cs_i;
    logic          mosi_i;
    logic [DW-1:0] sample_i;
    logic          miso_o;
    logic [7:0]    cmd_o;
    logic [2:0]    chan_o;
    logic          cmd_vld_o;
    logic          busy_o;
    logic          done_o;

    always #5 clk_i = ~clk_i;

    spi_adc_slave #(.SYNC_STAGES(SS), .DW(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .dclk_i(dclk_i), .cs_i(cs_i),
        .mosi_i(mosi_i), .sample_i(sample_i), .miso_o(miso_o),
        .cmd_o(cmd_o), .chan_o(chan_o), .cmd_vld_o(cmd_vld_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    int errors = 0;
    int checks = 0;

    // Model of the steady-state outputs.
    logic        exp_miso = 1'b0;
    logic        exp_busy = 1'b0;
    logic [7:0]  exp_cmd  = 8'd0;
    logic [2:0]  exp_chan = 3'd0;
    logic [11:0] ramp_m   = 12'd0;
    int          ev_id    = 0;

    // Strobe counters. Only the compare process writes them.
    int vld_seen  = 0;
    int done_seen = 0;

    // Frame-level checks posted by the stimulus. The compare process evaluates them.
    string       q_name[$];
    logic [31:0] q_act[$];
    logic [31:0] q_exp[$];

    task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
        q_name.push_back(n);
        q_act.push_back(a);
        q_exp.push_back(e);
    endtask

    // Compare process: per-cycle steady-state checks plus the posted frame checks.
    int last_ev = -1;
    int quiet   = 0;
    always @(negedge clk_i) begin
        if (ev_id != last_ev) begin
            last_ev = ev_id;
            quiet   = 0;
        end else begin
            quiet = quiet + 1;
        end
        if (cmd_vld_o === 1'b1) vld_seen = vld_seen + 1;
        if (done_o === 1'b1) done_seen = done_seen + 1;
        if (quiet >= SS + 2) begin
            checks = checks + 4;
            if (miso_o !== exp_miso) begin
                errors = errors + 1;
                $display("FAIL miso t=%0t: got %0b expected %0b", $time, miso_o, exp_miso);
            end
            if (busy_o !== exp_busy) begin
                errors = errors + 1;
                $display("FAIL busy t=%0t: got %0b expected %0b", $time, busy_o, exp_busy);
            end
            if (cmd_o !== exp_cmd) begin
                errors = errors + 1;
                $display("FAIL cmd t=%0t: got %0h expected %0h", $time, cmd_o, exp_cmd);
            end
            if (chan_o !== exp_chan) begin
                errors = errors + 1;
                $display("FAIL chan t=%0t: got %0d expected %0d", $time, chan_o, exp_chan);
            end
        end
        while (q_name.size() > 0) begin
            checks = checks + 1;
            if (q_act[0] !== q_exp[0]) begin
                errors = errors + 1;
                $display("FAIL %s: got %0h expected %0h", q_name[0], q_act[0], q_exp[0]);
            end
            void'(q_name.pop_front());
            void'(q_act.pop_front());
            void'(q_exp.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    logic [11:0] last_dout;

    // One master frame. abort_at>0 raises cs after that many edges. coinc drops cs together with a dclk rise.
    task automatic frame(input logic [7:0] cmd, input logic [11:0] smp, input logic [11:0] post_smp,
                         input int nedges, input int abort_at, input bit coinc, input string tag);
        int          h;
        int          v0;
        int          d0;
        int          edges_done;
        logic        start;
        logic [11:0] ret;
        logic [11:0] dout;
        h     = 8 + int'($urandom_range(0, 4));
        start = cmd[7];
`ifdef ADC_EMU_RAMP_EN
        ret = ramp_m;
`else
        ret = smp;
`endif
        sample_i = smp;
        dout     = 12'd0;
        v0       = vld_seen;
        d0       = done_seen;
        tick(h);
        cs_i = 1'b0;
        if (coinc) dclk_i = 1'b1;
        ev_id    = ev_id + 1;
        exp_busy = 1'b1;
        exp_miso = 1'b0;
        tick(h);
        if (coinc) begin
            dclk_i = 1'b0;
            ev_id  = ev_id + 1;
            tick(h);
        end
        edges_done = 0;
        for (int k = 1; k <= nedges; k++) begin
            if (abort_at != 0 && k > abort_at) break;
            mosi_i = (k <= 8) ? cmd[8-k] : 1'($urandom);
            tick(h);
            if (k >= 10 && k <= 21) dout = {dout[10:0], miso_o};
            dclk_i = 1'b1;
            ev_id  = ev_id + 1;
            if (k == 8 && start) begin
                exp_cmd  = cmd;
                exp_chan = cmd[6:4];
            end
            tick(h);
            dclk_i   = 1'b0;
            ev_id    = ev_id + 1;
            exp_miso = (start && k >= 9 && k <= 20) ? ret[20-k] : 1'b0;
            if (k == 8) sample_i = post_smp;
            edges_done = k;
        end
        tick(h);
        cs_i     = 1'b1;
        mosi_i   = 1'b0;
        ev_id    = ev_id + 1;
        exp_busy = 1'b0;
        exp_miso = 1'b0;
        tick(h);
        post({tag, "_vld_cnt"}, 32'(vld_seen - v0), (start && edges_done >= 8) ? 32'd1 : 32'd0);
        post({tag, "_done_cnt"}, 32'(done_seen - d0), (start && edges_done >= 24) ? 32'd1 : 32'd0);
        if (edges_done >= 21) post({tag, "_dout"}, 32'(dout), start ? 32'(ret) : 32'd0);
        if (start && edges_done >= 24) ramp_m = 12'(ramp_m + 12'(exp_chan) + 12'd1);
        last_dout = dout;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rc;
        int         ne;
        int         ab;
        bit         co;
        rst_i    = 1'b0;
        dclk_i   = 1'b0;
        cs_i     = 1'b1;
        mosi_i   = 1'b0;
        sample_i = 12'd0;
        last_dout = 12'd0;
        tick(5);
        post("rst_miso", 32'(miso_o), 32'd0);
        post("rst_busy", 32'(busy_o), 32'd0);
        post("rst_cmd", 32'(cmd_o), 32'd0);
        post("rst_chan", 32'(chan_o), 32'd0);
        post("rst_vld", 32'(cmd_vld_o), 32'd0);
        post("rst_done", 32'(done_o), 32'd0);
        rst_i = 1'b1;
        tick(5);

`ifdef ADC_EMU_RAMP_EN
        frame(8'h80, 12'h5A5, 12'h123, 24, 0, 1'b0, "ramp0");
        post("ramp0_lit", 32'(last_dout), 32'h000);
        frame(8'h80, 12'h5A5, 12'h123, 24, 0, 1'b0, "ramp1");
        post("ramp1_lit", 32'(last_dout), 32'h001);
        frame(8'h80, 12'h5A5, 12'h123, 24, 0, 1'b0, "ramp2");
        post("ramp2_lit", 32'(last_dout), 32'h002);
`else
        frame(8'b10010111, 12'hA5C, 12'h3C3, 24, 0, 1'b0, "a5c");
        post("a5c_lit", 32'(last_dout), 32'hA5C);
        post("a5c_chan", 32'(chan_o), 32'h1);
        post("a5c_cmd", 32'(cmd_o), 32'h97);
        frame(8'b11010111, 12'h001, 12'hFFF, 24, 0, 1'b0, "hold");
        post("hold_lit", 32'(last_dout), 32'h001);
        post("hold_chan", 32'(chan_o), 32'h5);
        frame(8'b00010111, 12'hABC, 12'h123, 24, 0, 1'b0, "nostart");
        post("nostart_lit", 32'(last_dout), 32'h000);
        post("nostart_cmd", 32'(cmd_o), 32'hD7);
        frame(8'b10100000, 12'h123, 12'h456, 24, 12, 1'b0, "abort");
        frame(8'b10000000, 12'h800, 12'h7FF, 24, 0, 1'b0, "after_abort");
        post("after_abort_lit", 32'(last_dout), 32'h800);
        frame(8'b10110001, 12'h6E9, 12'h000, 26, 0, 1'b0, "extra");
        frame(8'b11110000, 12'h3F0, 12'h000, 24, 0, 1'b1, "coinc");
        post("coinc_lit", 32'(last_dout), 32'h3F0);
`endif

        for (int i = 0; i < 18; i++) begin
            rc = 8'($urandom);
            if ($urandom_range(0, 4) != 0) rc[7] = 1'b1;
            ne = ($urandom_range(0, 3) == 0) ? 24 + int'($urandom_range(1, 3)) : 24;
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 23)) : 0;
            co = ($urandom_range(0, 5) == 0);
            frame(rc, 12'($urandom), 12'($urandom), ne, ab, co, "rnd");
        end

        // Reset asserted mid-frame after edge 5.
        cs_i     = 1'b0;
        ev_id    = ev_id + 1;
        exp_busy = 1'b1;
        tick(9);
        for (int k = 1; k <= 5; k++) begin
            mosi_i = 1'b1;
            tick(9);
            dclk_i = 1'b1;
            ev_id  = ev_id + 1;
            tick(9);
            dclk_i = 1'b0;
            ev_id  = ev_id + 1;
        end
        rst_i    = 1'b0;
        ev_id    = ev_id + 1;
        exp_busy = 1'b0;
        exp_miso = 1'b0;
        exp_cmd  = 8'd0;
        exp_chan = 3'd0;
        ramp_m   = 12'd0;
        #1;
        post("mid_rst_miso", 32'(miso_o), 32'd0);
        post("mid_rst_busy", 32'(busy_o), 32'd0);
        post("mid_rst_cmd", 32'(cmd_o), 32'd0);
        post("mid_rst_chan", 32'(chan_o), 32'd0);
        cs_i   = 1'b1;
        mosi_i = 1'b0;
        tick(4);
        rst_i = 1'b1;
        ev_id = ev_id + 1;
        tick(8);
        frame(8'b10010111, 12'hA5C, 12'h000, 24, 0, 1'b0, "post_rst");

        tick(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
